// File: rtl/vga_timing_pkg.sv
// Shared raster constants and types for the VGA timing generator
// and the sprite blocks that consume its scan position.
package vga_timing_pkg;

    localparam int COORD_W   = 10;
    localparam int COORD_MAX = 1 << COORD_W;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int HS_END   = HS_START + DEF_H_SYNC - 1;
    localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int VS_END   = VS_START + DEF_V_SYNC - 1;

    localparam logic [11:0] COLOR_BLACK = 12'h000;
    localparam logic [11:0] COLOR_WHITE = 12'hFFF;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic video;
        logic hsync;
        logic vsync;
    } sync_t;

    function automatic logic in_win(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register with a per-bit reset value; depth 0
// degenerates to a combinational pass-through.
module sync_delay_line #(
    parameter int           W       = 3,
    parameter int           DEPTH   = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_ok;
            assign unused_ok = ^{clk, reset, en_i};
            assign q_o = d_i;
        end else begin : g_pipe
            logic [DEPTH-1:0][W-1:0] stage_q, stage_d;

            always_comb begin
                stage_d = stage_q;
                if (en_i) begin
                    stage_d[0] = d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_d[i] = stage_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) stage_q <= {DEPTH{RST_VAL}};
                else       stage_q <= stage_d;
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan counters, sync/video decode and a pixel-aligned delayed
// copy of the syncs for sprite blocks with registered ROM lookups.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE    = DEF_H_ACTIVE,
    parameter int   H_FP        = DEF_H_FP,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BP        = DEF_H_BP,
    parameter int   V_ACTIVE    = DEF_V_ACTIVE,
    parameter int   V_FP        = DEF_V_FP,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BP        = DEF_V_BP,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   PIX_DIV     = 4,
    parameter int   PIPE_DLY    = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pix_en,
    output logic [COORD_W-1:0] pix_col,
    output logic [COORD_W-1:0] pix_row,
    output logic               video_on,
    output logic               horiz_sync,
    output logic               vert_sync,
    output logic               frame_tick,
    output logic               video_on_dly,
    output logic               horiz_sync_dly,
    output logic               vert_sync_dly
);

    localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (HT > COORD_MAX || VT > COORD_MAX) begin : g_bad_total
            $error("vga_timing_gen: raster total exceeds 10-bit coordinates");
        end
        if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_div
            $error("vga_timing_gen: PIX_DIV out of range");
        end
        if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
            $error("vga_timing_gen: PIPE_DLY out of range");
        end
    endgenerate

    localparam coord_t     H_LAST   = coord_t'(HT - 1);
    localparam coord_t     V_LAST   = coord_t'(VT - 1);
    localparam coord_t     H_ACT    = coord_t'(H_ACTIVE);
    localparam coord_t     V_ACT    = coord_t'(V_ACTIVE);
    localparam coord_t     HS_LO    = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t     HS_HI    = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t     VS_LO    = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t     VS_HI    = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);

    localparam sync_t SYNC_RST = '{video: 1'b1, hsync: ~SYNC_ACTIVE, vsync: ~SYNC_ACTIVE};
    localparam sync_t DLY_RST  = '{video: 1'b0, hsync: ~SYNC_ACTIVE, vsync: ~SYNC_ACTIVE};

    logic [3:0] div_q, div_d;
    logic       en_q, en_d;
    coord_t     col_q, col_d;
    coord_t     row_q, row_d;
    sync_t      sync_q, sync_d;
    logic       tick_q, tick_d;
    sync_t      sync_dly;

    // Decode runs on the next counter values so the flags line up with them.
    always_comb begin
        div_d = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
        en_d  = (div_d == DIV_LAST);
        col_d = col_q;
        row_d = row_q;
        if (en_q) begin
            if (col_q == H_LAST) begin
                col_d = '0;
                row_d = (row_q == V_LAST) ? '0 : row_q + coord_t'(1);
            end else begin
                col_d = col_q + coord_t'(1);
            end
        end
        sync_d.video = (col_d < H_ACT) && (row_d < V_ACT);
        sync_d.hsync = in_win(col_d, HS_LO, HS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        sync_d.vsync = in_win(row_d, VS_LO, VS_HI) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        tick_d = en_q && (col_q == H_LAST) && (row_q == V_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            en_q   <= 1'b0;
            col_q  <= '0;
            row_q  <= '0;
            sync_q <= SYNC_RST;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            en_q   <= en_d;
            col_q  <= col_d;
            row_q  <= row_d;
            sync_q <= sync_d;
            tick_q <= tick_d;
        end
    end

    sync_delay_line #(
        .W      (3),
        .DEPTH  (PIPE_DLY),
        .RST_VAL(DLY_RST)
    ) u_dly (
        .clk  (clk),
        .reset(reset),
        .en_i (en_q),
        .d_i  (sync_q),
        .q_o  (sync_dly)
    );

    assign pix_en         = en_q;
    assign pix_col        = col_q;
    assign pix_row        = row_q;
    assign video_on       = sync_q.video;
    assign horiz_sync     = sync_q.hsync;
    assign vert_sync      = sync_q.vsync;
    assign frame_tick     = tick_q;
    assign video_on_dly   = sync_dly.video;
    assign horiz_sync_dly = sync_dly.hsync;
    assign vert_sync_dly  = sync_dly.vsync;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench for vga_timing_gen: default timing, fast pixel
// rate and a shrunken raster for whole-frame and mid-frame reset runs.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       en;
        logic [9:0] col;
        logic [9:0] row;
        logic       vid;
        logic       hs;
        logic       vs;
        logic       tk;
        logic       dv;
        logic       dh;
        logic       dvs;
    } exp_t;

    typedef struct {
        int d, p, ha, hf, hs, hb, va, vf, vs, vb;
    } cfg_t;

    typedef struct {
        int   id;
        exp_t e;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_c = 1'b1;
    always #5 clk = ~clk;

    logic       a_en, a_vid, a_hs, a_vs, a_tk, a_dv, a_dh, a_dvs;
    logic       b_en, b_vid, b_hs, b_vs, b_tk, b_dv, b_dh, b_dvs;
    logic       c_en, c_vid, c_hs, c_vs, c_tk, c_dv, c_dh, c_dvs;
    logic [9:0] a_col, a_row, b_col, b_row, c_col, c_row;

    vga_timing_gen u_a (
        .clk(clk), .reset(rst), .pix_en(a_en), .pix_col(a_col), .pix_row(a_row),
        .video_on(a_vid), .horiz_sync(a_hs), .vert_sync(a_vs), .frame_tick(a_tk),
        .video_on_dly(a_dv), .horiz_sync_dly(a_dh), .vert_sync_dly(a_dvs)
    );

    vga_timing_gen #(.PIX_DIV(1), .PIPE_DLY(0)) u_b (
        .clk(clk), .reset(rst), .pix_en(b_en), .pix_col(b_col), .pix_row(b_row),
        .video_on(b_vid), .horiz_sync(b_hs), .vert_sync(b_vs), .frame_tick(b_tk),
        .video_on_dly(b_dv), .horiz_sync_dly(b_dh), .vert_sync_dly(b_dvs)
    );

    vga_timing_gen #(
        .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(10),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(3),
        .PIX_DIV(2), .PIPE_DLY(3)
    ) u_c (
        .clk(clk), .reset(rst_c), .pix_en(c_en), .pix_col(c_col), .pix_row(c_row),
        .video_on(c_vid), .horiz_sync(c_hs), .vert_sync(c_vs), .frame_tick(c_tk),
        .video_on_dly(c_dv), .horiz_sync_dly(c_dh), .vert_sync_dly(c_dvs)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, wanted %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic cfg_t cfg_of(int id);
        cfg_t c;
        case (id)
            0:       c = '{4, 2, 640, 16, 96, 48, 480, 10, 2, 33};
            1:       c = '{1, 0, 640, 16, 96, 48, 480, 10, 2, 33};
            default: c = '{2, 3, 20, 4, 6, 10, 12, 2, 3, 3};
        endcase
        return c;
    endfunction

    // pixel steps completed after n clock edges out of reset
    function automatic int kof(int n, int d);
        if (n <= 0) return 0;
        return n / d - ((d == 1) ? 1 : 0);
    endfunction

    function automatic logic [2:0] dec(int j, cfg_t c);
        int ht, vt, col, row;
        logic v, h, s;
        if (j < 0) return 3'b011;
        ht  = c.ha + c.hf + c.hs + c.hb;
        vt  = c.va + c.vf + c.vs + c.vb;
        col = j % ht;
        row = (j / ht) % vt;
        v = (col < c.ha) && (row < c.va);
        h = !((col >= c.ha + c.hf) && (col < c.ha + c.hf + c.hs));
        s = !((row >= c.va + c.vf) && (row < c.va + c.vf + c.vs));
        return {v, h, s};
    endfunction

    function automatic exp_t model(int n, int id);
        cfg_t c = cfg_of(id);
        exp_t e;
        int ht, vt, k, kp;
        logic [2:0] u, dl;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        k  = kof(n, c.d);
        kp = kof(n - 1, c.d);
        u  = dec(k, c);
        dl = dec(k - c.p, c);
        e.en  = (n > 0) && ((n % c.d) == (c.d - 1));
        e.col = 10'(k % ht);
        e.row = 10'((k / ht) % vt);
        {e.vid, e.hs, e.vs} = u;
        e.tk  = (n > 0) && (k != kp) && (k > 0) && ((k % (ht * vt)) == 0);
        {e.dv, e.dh, e.dvs} = dl;
        return e;
    endfunction

    sb_t sb[$];
    int  nA = 0;
    int  nC = 0;

    initial forever begin
        @(posedge clk);
        nA = rst ? 0 : nA + 1;
        nC = rst_c ? 0 : nC + 1;
        sb.push_back('{id: 0, e: model(nA, 0)});
        sb.push_back('{id: 1, e: model(nA, 1)});
        sb.push_back('{id: 2, e: model(nC, 2)});
    end

    initial forever begin
        sb_t   it;
        exp_t  o;
        string p;
        @(negedge clk);
        while (sb.size() > 0) begin
            it = sb.pop_front();
            case (it.id)
                0:       begin o = {a_en, a_col, a_row, a_vid, a_hs, a_vs, a_tk, a_dv, a_dh, a_dvs}; p = "A"; end
                1:       begin o = {b_en, b_col, b_row, b_vid, b_hs, b_vs, b_tk, b_dv, b_dh, b_dvs}; p = "B"; end
                default: begin o = {c_en, c_col, c_row, c_vid, c_hs, c_vs, c_tk, c_dv, c_dh, c_dvs}; p = "C"; end
            endcase
            check({p, ".pix_en"}, int'(o.en), int'(it.e.en));
            check({p, ".pix_col"}, int'(o.col), int'(it.e.col));
            check({p, ".pix_row"}, int'(o.row), int'(it.e.row));
            check({p, ".video_on"}, int'(o.vid), int'(it.e.vid));
            check({p, ".horiz_sync"}, int'(o.hs), int'(it.e.hs));
            check({p, ".vert_sync"}, int'(o.vs), int'(it.e.vs));
            check({p, ".frame_tick"}, int'(o.tk), int'(it.e.tk));
            check({p, ".video_on_dly"}, int'(o.dv), int'(it.e.dv));
            check({p, ".horiz_sync_dly"}, int'(o.dh), int'(it.e.dh));
            check({p, ".vert_sync_dly"}, int'(o.dvs), int'(it.e.dvs));
        end
    end

    int a_hs_cnt = 0, a_hs_first = -1, a_hs_last = -1, a_vid_low = 0, a_dh_first = -1;
    int tclk = 0, b_t1 = -1, b_t2 = -1, b_hs_cnt = 0;
    int c_ticks = 0, c_cnt = 0, c_period = -1, c_vs_first = -1, c_vs_last = -1;
    bit c_have = 0;

    initial forever begin
        @(negedge clk);
        tclk++;
        if (!rst && a_en && a_row == 10'd0) begin
            if (!a_hs) begin
                a_hs_cnt++;
                if (a_hs_first < 0) a_hs_first = int'(a_col);
                a_hs_last = int'(a_col);
            end
            if (!a_vid) a_vid_low++;
            if (!a_dh && a_dh_first < 0) a_dh_first = int'(a_col);
        end
        if (!rst) begin
            if (b_row == 10'd1 && b_t1 < 0) b_t1 = tclk;
            if (b_row == 10'd2 && b_t2 < 0) b_t2 = tclk;
            if (b_row == 10'd1 && !b_hs) b_hs_cnt++;
        end
        if (rst_c) begin
            c_have = 0;
            c_cnt  = 0;
        end else begin
            if (c_tk) begin
                if (c_have && c_period < 0) c_period = c_cnt;
                c_have = 1;
                c_cnt  = 0;
                c_ticks++;
            end
            if (c_en) c_cnt++;
            if (c_en && !c_vs) begin
                if (c_vs_first < 0) c_vs_first = int'(c_row);
                c_vs_last = int'(c_row);
            end
        end
    end

    initial begin
        int t0;
        repeat (10) @(negedge clk);
        rst   = 1'b0;
        rst_c = 1'b0;
        repeat (4452) @(negedge clk);
        check("C.pre_rst_col", int'(c_col), 26);
        check("C.pre_rst_row", int'(c_row), 15);
        check("C.pre_rst_hs", int'(c_hs), 0);
        check("C.pre_rst_vs", int'(c_vs), 0);
        check("C.ticks_pre_rst", c_ticks, 2);
        check("C.frame_pix_steps", c_period, 800);
        #2 rst_c = 1'b1;
        #1;
        check("C.async_col", int'(c_col), 0);
        check("C.async_row", int'(c_row), 0);
        check("C.async_hs", int'(c_hs), 1);
        check("C.async_vs", int'(c_vs), 1);
        check("C.async_vid", int'(c_vid), 1);
        check("C.async_en", int'(c_en), 0);
        check("C.async_dly_vid", int'(c_dv), 0);
        check("C.async_dly_hs", int'(c_dh), 1);
        repeat (3) @(negedge clk);
        rst_c = 1'b0;
        t0 = c_ticks;
        repeat (20) @(negedge clk);
        check("C.no_stray_tick", c_ticks - t0, 0);
        repeat (1980) @(negedge clk);
        check("C.ticks_post_rst", c_ticks - t0, 1);
        #1;
        check("A.hs_pixels", a_hs_cnt, 96);
        check("A.hs_first_col", a_hs_first, 656);
        check("A.hs_last_col", a_hs_last, 751);
        check("A.video_low_pixels", a_vid_low, 160);
        check("A.hs_dly_first_col", a_dh_first, 658);
        check("B.line_clks", b_t2 - b_t1, 800);
        check("B.hs_clks", b_hs_cnt, 96);
        check("C.vs_first_row", c_vs_first, 14);
        check("C.vs_last_row", c_vs_last, 16);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
